msu_audio_player: RTL and testbench

- Downstream consumer of the MSU-1 register block: takes its track trigger, play/repeat control and volume, and turns the HPS-supplied PCM word stream into 44.1 kHz stereo samples for the SNES audio mixer.
- Buffers HPS words in a small FIFO, paces output with a fractional sample-rate divider, applies volume, and on end of data either re-seeks to the track loop point or stops.

---
 rtl/msu_audio_player.sv | 160 ++++++++++++++++
 tb/tb_msu_audio_player.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_audio_player.sv
// MSU-1 audio player: buffers HPS stereo PCM words, paces them out at the sample rate
// with volume applied, and either loops back to the track loop point or stops at end of data.
module msu_audio_player #(
   parameter int CLK_HZ     = 21477270,
   parameter int SAMPLE_HZ  = 44100,
   parameter int FIFO_DEPTH = 16,
   parameter int FILL_LEVEL = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        TRIG_PLAY,
   input  logic        TRACK_MOUNTING,
   input  logic        TRACK_MISSING,
   input  logic        PLAYING,
   input  logic        REPEAT,
   input  logic [7:0]  VOLUME,
   input  logic [31:0] LOOP_POINT,
   input  logic [31:0] DATA_WORD,
   input  logic        DATA_VALID,
   output logic        DATA_READY,
   input  logic        END_OF_DATA,
   output logic        SEEK_REQ,
   output logic [31:0] SEEK_SAMPLE,
   input  logic        SEEK_ACK,
   output logic [15:0] SAMPLE_L,
   output logic [15:0] SAMPLE_R,
   output logic        SAMPLE_STB,
   output logic        STOPPED,
   output logic        UNDERRUN
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [31:0]   SAMPLE_INC = 32'(SAMPLE_HZ);
   localparam logic [31:0]   CLK_MOD    = 32'(CLK_HZ);
   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] FILL_C     = CW'(FILL_LEVEL);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOUNT,
      ST_FILL,
      ST_PLAY,
      ST_SEEK
   } state_t;

   state_t        state;
   logic [31:0]   acc;
   logic [31:0]   acc_sum;
   logic          tick;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          eot;
   logic          underrun_tick;
   logic [31:0]   head_word;

   // Signed 16x9 product; the arithmetic shift floors toward minus infinity.
   function automatic logic [15:0] apply_volume(input logic signed [15:0] s,
                                                input logic [7:0] vol);
      logic signed [24:0] prod;
      prod = 25'(s) * 25'($signed({1'b0, vol}));
      return 16'(prod >>> 8);
   endfunction

   assign acc_sum       = acc + SAMPLE_INC;
   assign tick          = (acc_sum >= CLK_MOD);
   assign fifo_empty    = (count == '0);
   assign fifo_full     = (count == DEPTH_C);
   assign DATA_READY    = ((state == ST_FILL) || (state == ST_PLAY)) && !fifo_full;
   assign push          = DATA_VALID && DATA_READY;
   assign pop           = (state == ST_PLAY) && tick && PLAYING && !fifo_empty;
   assign eot           = ((state == ST_FILL) || (state == ST_PLAY)) && fifo_empty && END_OF_DATA;
   assign underrun_tick = (state == ST_PLAY) && tick && PLAYING && fifo_empty && !END_OF_DATA;
   assign head_word     = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= DATA_WORD;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= ST_IDLE;
         acc         <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         SEEK_REQ    <= 1'b0;
         SEEK_SAMPLE <= '0;
         SAMPLE_L    <= '0;
         SAMPLE_R    <= '0;
         SAMPLE_STB  <= 1'b0;
         STOPPED     <= 1'b0;
         UNDERRUN    <= 1'b0;
      end else begin
         acc        <= tick ? (acc_sum - CLK_MOD) : acc_sum;
         SAMPLE_STB <= tick;
         STOPPED    <= 1'b0;
         UNDERRUN   <= 1'b0;
         // Every tick strobes; it carries silence unless a word is popped below.
         if (tick) begin
            SAMPLE_L <= '0;
            SAMPLE_R <= '0;
         end
         if (TRIG_PLAY) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            SEEK_REQ <= 1'b0;
            SAMPLE_L <= '0;
            SAMPLE_R <= '0;
            state    <= ST_MOUNT;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
               rd_ptr   <= rd_ptr + AW'(1);
               SAMPLE_L <= apply_volume(head_word[15:0], VOLUME);
               SAMPLE_R <= apply_volume(head_word[31:16], VOLUME);
            end
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (underrun_tick) UNDERRUN <= 1'b1;

            case (state)
               ST_MOUNT: begin
                  if (!TRACK_MOUNTING) state <= TRACK_MISSING ? ST_IDLE : ST_FILL;
               end
               ST_FILL, ST_PLAY: begin
                  if (eot) begin
                     if (REPEAT) begin
                        SEEK_REQ    <= 1'b1;
                        SEEK_SAMPLE <= LOOP_POINT;
                        state       <= ST_SEEK;
                     end else begin
                        STOPPED <= 1'b1;
                        state   <= ST_IDLE;
                     end
                  end else if (state == ST_FILL &&
                               (count >= FILL_C || (END_OF_DATA && !fifo_empty))) begin
                     state <= ST_PLAY;
                  end
               end
               ST_SEEK: begin
                  if (SEEK_ACK) begin
                     SEEK_REQ <= 1'b0;
                     state    <= ST_FILL;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_msu_audio_player.sv
// Scoreboard bench for msu_audio_player: accepted words are queued and compared,
// volume-scaled, against each non-silent strobed sample.
module tb_msu_audio_player;

   localparam int CLK_HZ    = 10;
   localparam int SAMPLE_HZ = 3;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        TRIG_PLAY = 1'b0;
   logic        TRACK_MOUNTING = 1'b0;
   logic        TRACK_MISSING = 1'b0;
   logic        PLAYING = 1'b0;
   logic        REPEAT = 1'b0;
   logic [7:0]  VOLUME = 8'hFF;
   logic [31:0] LOOP_POINT = '0;
   logic [31:0] DATA_WORD = '0;
   logic        DATA_VALID = 1'b0;
   logic        DATA_READY;
   logic        END_OF_DATA = 1'b0;
   logic        SEEK_REQ;
   logic [31:0] SEEK_SAMPLE;
   logic        SEEK_ACK = 1'b0;
   logic [15:0] SAMPLE_L;
   logic [15:0] SAMPLE_R;
   logic        SAMPLE_STB;
   logic        STOPPED;
   logic        UNDERRUN;

   msu_audio_player #(
      .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .FIFO_DEPTH(16), .FILL_LEVEL(8)
   ) dut (
      .CLK(CLK), .RESET(RESET), .TRIG_PLAY(TRIG_PLAY), .TRACK_MOUNTING(TRACK_MOUNTING),
      .TRACK_MISSING(TRACK_MISSING), .PLAYING(PLAYING), .REPEAT(REPEAT), .VOLUME(VOLUME),
      .LOOP_POINT(LOOP_POINT), .DATA_WORD(DATA_WORD), .DATA_VALID(DATA_VALID),
      .DATA_READY(DATA_READY), .END_OF_DATA(END_OF_DATA), .SEEK_REQ(SEEK_REQ),
      .SEEK_SAMPLE(SEEK_SAMPLE), .SEEK_ACK(SEEK_ACK), .SAMPLE_L(SAMPLE_L),
      .SAMPLE_R(SAMPLE_R), .SAMPLE_STB(SAMPLE_STB), .STOPPED(STOPPED), .UNDERRUN(UNDERRUN)
   );

   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_err = 0;
   int          nz_cnt = 0;
   int          ur_cnt = 0;
   int          stb_cnt = 0;
   int          stop_cnt = 0;
   int          word_idx = 0;
   logic        ready_seen = 1'b0;
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Floor of s*vol/256 computed with integer division.
   function automatic logic [15:0] ref_scale(input logic [15:0] s, input logic [7:0] v);
      int p;
      p = int'($signed(s)) * int'(v);
      if (p >= 0) p = p / 256;
      else        p = -((-p + 255) / 256);
      return 16'(p);
   endfunction

   function automatic logic [31:0] gen_word(input int k);
      if (k == 0) return 32'h7FFF_8000;
      if (k == 1) return 32'h1000_F000;
      return {16'(k * 517 + 300), 16'(-(k * 263 + 200))};
   endfunction

   // Monitor: records accepted words and checks every strobed output.
   initial begin
      logic [31:0] w;
      forever begin
         @(negedge CLK);
         if (!RESET) begin
            if (DATA_VALID && DATA_READY && !TRIG_PLAY) exp_q.push_back(DATA_WORD);
            if (DATA_READY) ready_seen = 1'b1;
            if (STOPPED) stop_cnt++;
            if (SAMPLE_STB) begin
               stb_cnt++;
               if (UNDERRUN) begin
                  ur_cnt++;
                  check("underrun_out", {SAMPLE_R, SAMPLE_L}, 32'h0);
               end else if (SAMPLE_L != 16'h0 || SAMPLE_R != 16'h0) begin
                  nz_cnt++;
                  if (exp_q.size() == 0) begin
                     check("unexpected_sample", {SAMPLE_R, SAMPLE_L}, 32'h0);
                  end else begin
                     w = exp_q.pop_front();
                     check("sample_L", {16'h0, SAMPLE_L}, {16'h0, ref_scale(w[15:0], VOLUME)});
                     check("sample_R", {16'h0, SAMPLE_R}, {16'h0, ref_scale(w[31:16], VOLUME)});
                  end
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_word();
      int   t;
      logic timed_out;
      t = 0;
      timed_out = 1'b0;
      DATA_WORD = gen_word(word_idx);
      word_idx++;
      DATA_VALID = 1'b1;
      while (1) begin
         @(negedge CLK);
         if (DATA_READY) break;
         t++;
         if (t > 500) begin
            timed_out = 1'b1;
            break;
         end
      end
      if (timed_out) check("send_timeout", 32'(timed_out), 32'h0);
      @(posedge CLK);
      #1;
      DATA_VALID = 1'b0;
   endtask

   function automatic bit cond(input int which, input int ref_v);
      case (which)
         0:       return SEEK_REQ == 1'b1;
         1:       return stop_cnt != ref_v;
         2:       return ur_cnt != ref_v;
         default: return exp_q.size() == 0;
      endcase
   endfunction

   task automatic wait_cond(input int which, input int ref_v, input string tag);
      int   t;
      logic timed_out;
      t = 0;
      timed_out = 1'b0;
      while (!cond(which, ref_v)) begin
         @(negedge CLK);
         t++;
         if (t > 800) begin
            timed_out = 1'b1;
            break;
         end
      end
      check(tag, 32'(timed_out), 32'h0);
      step(1);
   endtask

   task automatic start_track(input int mount_cycles, input logic missing);
      TRIG_PLAY = 1'b1;
      TRACK_MOUNTING = 1'b1;
      TRACK_MISSING = missing;
      step(1);
      TRIG_PLAY = 1'b0;
      exp_q.delete();
      ready_seen = 1'b0;
      step(mount_cycles);
      check("ready_in_mount", {31'h0, ready_seen}, 32'h0);
      TRACK_MOUNTING = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ref0;
      int ref1;
      int ref2;

      // Reset state
      step(3);
      check("rst_samples", {SAMPLE_R, SAMPLE_L}, 32'h0);
      check("rst_pulses", {29'h0, SAMPLE_STB, STOPPED, UNDERRUN}, 32'h0);
      check("rst_seek", {31'h0, SEEK_REQ}, 32'h0);
      check("rst_seek_sample", SEEK_SAMPLE, 32'h0);
      check("rst_ready", {31'h0, DATA_READY}, 32'h0);
      RESET = 1'b0;

      // Tick rate: 3/10 of cycles strobe over 1000 cycles
      @(posedge CLK);
      ref0 = stb_cnt;
      step(1000);
      check("tick_rate", 32'(stb_cnt - ref0), 32'd300);

      // Missing track
      start_track(5, 1'b1);
      ref0 = nz_cnt;
      step(20);
      check("missing_ready", {31'h0, ready_seen}, 32'h0);
      TRACK_MISSING = 1'b0;
      step(10);
      check("missing_idle", {31'h0, ready_seen}, 32'h0);
      check("missing_out", 32'(nz_cnt - ref0), 32'h0);

      // Normal playback, underrun, stop
      PLAYING = 1'b1;
      VOLUME = 8'hFF;
      REPEAT = 1'b0;
      start_track(10, 1'b0);
      ref0 = nz_cnt;
      repeat (7) send_word();
      step(30);
      check("fill_hold", 32'(nz_cnt - ref0), 32'h0);
      check("fill_ready", {31'h0, DATA_READY}, 32'h1);
      repeat (13) send_word();
      wait_cond(2, ur_cnt, "underrun_wait");
      check("underrun_drained", 32'(exp_q.size()), 32'h0);
      ref0 = ur_cnt;
      ref1 = nz_cnt;
      step(100);
      check("underrun_rate", 32'(ur_cnt - ref0), 32'd30);
      check("underrun_silent", 32'(nz_cnt - ref1), 32'h0);
      repeat (8) send_word();
      END_OF_DATA = 1'b1;
      ref0 = stop_cnt;
      wait_cond(1, ref0, "stop_wait");
      ref1 = stb_cnt;
      ref2 = nz_cnt;
      step(30);
      check("stop_once", 32'(stop_cnt - ref0), 32'h1);
      check("stop_drained", 32'(exp_q.size()), 32'h0);
      check("stop_idle_ready", {31'h0, DATA_READY}, 32'h0);
      check("stop_cadence", 32'(stb_cnt - ref1), 32'd9);
      check("stop_silent", 32'(nz_cnt - ref2), 32'h0);
      END_OF_DATA = 1'b0;

      // Loop to LOOP_POINT
      VOLUME = 8'h80;
      REPEAT = 1'b1;
      LOOP_POINT = 32'h0000_0123;
      start_track(3, 1'b0);
      repeat (20) send_word();
      END_OF_DATA = 1'b1;
      ref0 = stop_cnt;
      wait_cond(0, 0, "seek_wait");
      check("seek_drained", 32'(exp_q.size()), 32'h0);
      check("seek_sample", SEEK_SAMPLE, 32'h0000_0123);
      LOOP_POINT = 32'h0000_0555;
      step(10);
      check("seek_hold", {31'h0, SEEK_REQ}, 32'h1);
      check("seek_sample_hold", SEEK_SAMPLE, 32'h0000_0123);
      END_OF_DATA = 1'b0;
      SEEK_ACK = 1'b1;
      step(1);
      SEEK_ACK = 1'b0;
      check("seek_ack_req", {31'h0, SEEK_REQ}, 32'h0);
      check("seek_ack_fill", {31'h0, DATA_READY}, 32'h1);
      check("loop_no_stop", 32'(stop_cnt - ref0), 32'h0);
      repeat (10) send_word();
      REPEAT = 1'b0;
      END_OF_DATA = 1'b1;
      wait_cond(1, ref0, "loop_stop_wait");
      step(5);
      check("loop_drained", 32'(exp_q.size()), 32'h0);
      check("loop_stop_once", 32'(stop_cnt - ref0), 32'h1);
      END_OF_DATA = 1'b0;

      // Pause: FIFO fills to depth and holds
      VOLUME = 8'h40;
      PLAYING = 1'b0;
      start_track(3, 1'b0);
      ref0 = nz_cnt;
      repeat (16) send_word();
      DATA_WORD = gen_word(word_idx);
      DATA_VALID = 1'b1;
      ready_seen = 1'b0;
      step(20);
      check("full_ready", {31'h0, ready_seen}, 32'h0);
      DATA_VALID = 1'b0;
      check("pause_silent", 32'(nz_cnt - ref0), 32'h0);
      check("pause_buffered", 32'(exp_q.size()), 32'd16);
      PLAYING = 1'b1;
      wait_cond(3, 0, "pause_drain_wait");
      check("pause_played", 32'(nz_cnt - ref0), 32'd16);

      // Retrigger in the same cycle as SEEK_ACK
      REPEAT = 1'b1;
      LOOP_POINT = 32'h0000_0077;
      repeat (3) send_word();
      END_OF_DATA = 1'b1;
      wait_cond(0, 0, "retrig_seek_wait");
      check("retrig_seek_sample", SEEK_SAMPLE, 32'h0000_0077);
      TRIG_PLAY = 1'b1;
      SEEK_ACK = 1'b1;
      TRACK_MOUNTING = 1'b1;
      END_OF_DATA = 1'b0;
      step(1);
      TRIG_PLAY = 1'b0;
      SEEK_ACK = 1'b0;
      exp_q.delete();
      ready_seen = 1'b0;
      check("retrig_req", {31'h0, SEEK_REQ}, 32'h0);
      step(10);
      check("retrig_mount", {31'h0, ready_seen}, 32'h0);
      TRACK_MOUNTING = 1'b0;
      ref0 = nz_cnt;
      repeat (7) send_word();
      step(30);
      check("retrig_count0", 32'(nz_cnt - ref0), 32'h0);
      send_word();
      wait_cond(3, 0, "retrig_drain_wait");
      check("retrig_played", 32'(nz_cnt - ref0), 32'd8);

      // Reset while a seek is pending
      END_OF_DATA = 1'b1;
      wait_cond(0, 0, "rst_seek_wait");
      RESET = 1'b1;
      step(1);
      check("midrst_seek", {31'h0, SEEK_REQ}, 32'h0);
      check("midrst_out", {SAMPLE_R, SAMPLE_L}, 32'h0);
      check("midrst_pulses", {29'h0, SAMPLE_STB, STOPPED, UNDERRUN}, 32'h0);
      check("midrst_ready", {31'h0, DATA_READY}, 32'h0);
      RESET = 1'b0;
      END_OF_DATA = 1'b0;
      exp_q.delete();
      step(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
